// File: rtl/regfile_sb_pkg.sv
// Shared definitions for the parametrised register file with pending-write scoreboard.
package regfile_sb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  // Register 0 is hardwired to zero and never tracked.
  localparam int REG_ZERO = 0;

  localparam logic [DATA_W_DEF-1:0] ZeroWord = '0;

  localparam logic WriteEnable = 1'b1;
  localparam logic ReadEnable  = 1'b1;

  // True when an address names a real, writable register (not r0, not past the array).
  function automatic logic reg_in_range(input int unsigned addr, input int unsigned num_regs);
    return (addr != REG_ZERO) && (addr < num_regs);
  endfunction

endpackage

// File: rtl/regfile_sb_reg_scoreboard.sv
// Per-register in-flight write counters with busy and issue-ready generation.
module reg_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int PEND_W   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_waddr,
  input  logic                     flush,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD-1:0]        busy,
  output logic                     iss_ready
);

  localparam logic [PEND_W-1:0] CNT_MAX = '1;
  localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

  logic [NUM_REGS-1:0][PEND_W-1:0] count_q, count_d;
  logic              wb_hit, iss_hit, inc, dec;
  logic [PEND_W-1:0] iss_cnt, rd_cnt;
  logic [ADDR_W-1:0] rd_addr;

  // Count for an address; r0 and out-of-range addresses read as idle.
  function automatic logic [PEND_W-1:0] count_of(input logic [ADDR_W-1:0] a);
    return reg_in_range(32'(a), NUM_REGS) ? count_q[a] : '0;
  endfunction

  // Issue stalls only at a saturated counter, unless a writeback frees a slot this cycle.
  always_comb begin
    iss_cnt   = count_of(iss_waddr);
    iss_ready = !rst && ((iss_cnt != CNT_MAX) ||
                         (we && (waddr == iss_waddr) && (iss_cnt != '0)));
  end

  // Counter next state: flush clears everything, otherwise concurrent inc/dec cancel.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    wb_hit  = we && reg_in_range(32'(waddr), NUM_REGS);
    iss_hit = iss_valid && iss_ready && reg_in_range(32'(iss_waddr), NUM_REGS);
    inc     = 1'b0;
    dec     = 1'b0;
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        inc = iss_hit && (iss_waddr == ADDR_W'(r));
        dec = wb_hit && (waddr == ADDR_W'(r)) && (count_q[r] != '0);
        case ({inc, dec})
          2'b10:   count_d[r] = count_q[r] + CNT_ONE;
          2'b01:   count_d[r] = count_q[r] - CNT_ONE;
          default: count_d[r] = count_q[r];
        endcase
      end
    end
    count_d[REG_ZERO] = '0;
  end

  // A port is busy on a pending register, except when its last write lands this cycle.
  always_comb begin
    busy    = '0;
    rd_addr = '0;
    rd_cnt  = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_addr = raddr[i*ADDR_W +: ADDR_W];
      rd_cnt  = count_of(rd_addr);
      busy[i] = !rst && re[i] && (rd_cnt != '0) &&
                !(we && (waddr == rd_addr) && (rd_cnt == CNT_ONE));
    end
  end

  // Counter state register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file: storage, same-cycle write bypass, read port unflattening, scoreboard.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int PEND_W   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        busy,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_waddr,
  output logic                     iss_ready,
  input  logic                     flush
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
  logic [ADDR_W-1:0]               rd_addr [NUM_RD];
  logic [DATA_W-1:0]               rd_val;

  for (genvar g = 0; g < NUM_RD; g++) begin : g_unflat
    assign rd_addr[g] = raddr[g*ADDR_W +: ADDR_W];
  end

  // Writeback into storage; r0 and out-of-range addresses are dropped.
  always_ff @(posedge clk) begin
    // NOTE: the whole array is cleared on reset because software may read any register first.
    if (rst) begin
      regs_q <= '0;
    end else if ((we == WriteEnable) && reg_in_range(32'(waddr), NUM_REGS)) begin
      regs_q[waddr] <= wdata;
    end
  end

  // Combinational read with same-cycle bypass of the incoming writeback.
  always_comb begin
    rdata  = '0;
    rd_val = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_val = DATA_W'(ZeroWord);
      if (!rst && (re[i] == ReadEnable) && reg_in_range(32'(rd_addr[i]), NUM_REGS)) begin
        if ((we == WriteEnable) && (waddr == rd_addr[i])) rd_val = wdata;
        else                                              rd_val = regs_q[rd_addr[i]];
      end
      rdata[i*DATA_W +: DATA_W] = rd_val;
    end
  end

  reg_scoreboard #(
    .NUM_REGS(NUM_REGS),
    .ADDR_W  (ADDR_W),
    .NUM_RD  (NUM_RD),
    .PEND_W  (PEND_W)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .waddr    (waddr),
    .iss_valid(iss_valid),
    .iss_waddr(iss_waddr),
    .flush    (flush),
    .re       (re),
    .raddr    (raddr),
    .busy     (busy),
    .iss_ready(iss_ready)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb; expectations are queued at stimulus and popped at sampling.
module tb_regfile_sb;

  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_RD   = 2;
  localparam int PEND_W   = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     we;
  logic [ADDR_W-1:0]        waddr;
  logic [DATA_W-1:0]        wdata;
  logic [NUM_RD-1:0]        re;
  logic [NUM_RD*ADDR_W-1:0] raddr;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic [NUM_RD-1:0]        busy;
  logic                     iss_valid;
  logic [ADDR_W-1:0]        iss_waddr;
  logic                     iss_ready;
  logic                     flush;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } exp_t;

  exp_t sb_q[$];

  regfile_sb #(
    .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .PEND_W(PEND_W)
  ) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .rdata(rdata), .busy(busy),
    .iss_valid(iss_valid), .iss_waddr(iss_waddr), .iss_ready(iss_ready), .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [63:0] exp);
    sb_q.push_back('{tag, exp});
  endtask

  task automatic check(input logic [63:0] obs);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty observed=%0h", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int port, input logic [ADDR_W-1:0] a, input logic en);
    raddr[port*ADDR_W +: ADDR_W] = a;
    re[port] = en;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; re = '0; raddr = '0;
    iss_valid = 1'b0; iss_waddr = '0; flush = 1'b0;

    // Reset: every register reads zero on both ports, nothing busy, no issue.
    step();
    for (int r = 0; r < NUM_REGS; r++) begin
      set_rd(0, ADDR_W'(r), 1'b1);
      set_rd(1, ADDR_W'(r), 1'b1);
      #1;
      push($sformatf("rst_rdata_r%0d", r), 64'h0); check(64'(rdata));
      push($sformatf("rst_busy_r%0d", r), 64'h0);  check(64'(busy));
    end
    push("rst_iss_ready", 64'h0); check(64'(iss_ready));
    step();
    rst = 1'b0;
    #1;
    push("post_rst_iss_ready", 64'h1); check(64'(iss_ready));
    for (int r = 0; r < NUM_REGS; r += 7) begin
      set_rd(0, ADDR_W'(r), 1'b1);
      set_rd(1, ADDR_W'(NUM_REGS - 1 - r), 1'b1);
      #1;
      push($sformatf("post_rst_rdata_%0d", r), 64'h0); check(64'(rdata));
    end

    // Write r5 with a same-cycle read: bypass now, stored value next cycle.
    step();
    set_rd(0, 5, 1'b1); set_rd(1, 0, 1'b0);
    we = 1'b1; waddr = 5; wdata = 32'hDEAD_BEEF;
    #1;
    push("bypass_r5", 64'h0000_0000_DEAD_BEEF); check(64'(rdata));
    step();
    we = 1'b0;
    #1;
    push("stored_r5", 64'h0000_0000_DEAD_BEEF); check(64'(rdata));
    set_rd(0, 5, 1'b0);
    #1;
    push("re_off_r5", 64'h0); check(64'(rdata));

    // Writes to r0 are dropped and r0 always reads zero.
    set_rd(0, 0, 1'b1); set_rd(1, 0, 1'b1);
    we = 1'b1; waddr = 0; wdata = 32'h1234;
    #1;
    push("r0_bypass", 64'h0); check(64'(rdata));
    step();
    we = 1'b0;
    #1;
    push("r0_stored", 64'h0); check(64'(rdata));

    // Three issues to r7 saturate its counter; the fourth stalls.
    set_rd(0, 7, 1'b1); set_rd(1, 0, 1'b0);
    iss_valid = 1'b1; iss_waddr = 7;
    #1;
    push("r7_iss1_ready", 64'h1); check(64'(iss_ready));
    push("r7_cnt0_busy", 64'h0);  check(64'(busy));
    step();
    push("r7_iss2_ready", 64'h1); check(64'(iss_ready));
    push("r7_cnt1_busy", 64'h1);  check(64'(busy));
    step();
    push("r7_iss3_ready", 64'h1); check(64'(iss_ready));
    step();
    push("r7_iss4_stall", 64'h0); check(64'(iss_ready));
    push("r7_cnt3_busy", 64'h1);  check(64'(busy));
    step();
    // Writeback alongside the stalled issue frees a slot: accepted, count stays 3.
    we = 1'b1; waddr = 7; wdata = 32'h77;
    #1;
    push("r7_wb_exempt_ready", 64'h1); check(64'(iss_ready));
    push("r7_wb_cnt3_busy", 64'h1);    check(64'(busy));
    push("r7_wb_bypass", 64'h77);      check(64'(rdata));
    step();
    iss_valid = 1'b0; we = 1'b0;
    #1;
    push("r7_still_full", 64'h0); check(64'(iss_ready));
    push("r7_still_busy", 64'h1); check(64'(busy));
    // Drain r7 with three writebacks; the last one clears busy in its own cycle.
    step();
    we = 1'b1; waddr = 7; wdata = 32'h70;
    #1;
    push("r7_drain3_busy", 64'h1); check(64'(busy));
    step();
    push("r7_drain2_busy", 64'h1); check(64'(busy));
    step();
    push("r7_drain1_busy", 64'h0); check(64'(busy));
    step();
    we = 1'b0;
    #1;
    push("r7_idle_busy", 64'h0);  check(64'(busy));
    push("r7_idle_ready", 64'h1); check(64'(iss_ready));

    // Single pending write on r9 completes while port 1 reads it.
    iss_valid = 1'b1; iss_waddr = 9;
    step();
    iss_valid = 1'b0;
    set_rd(0, 0, 1'b0); set_rd(1, 9, 1'b1);
    #1;
    push("r9_busy", 64'h2); check(64'(busy));
    we = 1'b1; waddr = 9; wdata = 32'h9999;
    #1;
    push("r9_final_wb_busy", 64'h0);         check(64'(busy));
    push("r9_final_wb_rdata", 64'h9999 << 32); check(64'(rdata));
    step();
    we = 1'b0;
    #1;
    push("r9_after_busy", 64'h0);            check(64'(busy));
    push("r9_after_rdata", 64'h9999 << 32);  check(64'(rdata));

    // Pending counts on r3, r4, r12; flush with a concurrent issue and writeback.
    iss_valid = 1'b1; iss_waddr = 3;  step();
    iss_waddr = 4;                    step();
    iss_waddr = 12;                   step();
    step();
    iss_valid = 1'b0;
    set_rd(0, 3, 1'b1); set_rd(1, 12, 1'b1);
    #1;
    push("pre_flush_busy", 64'h3); check(64'(busy));
    flush = 1'b1; iss_valid = 1'b1; iss_waddr = 3;
    we = 1'b1; waddr = 4; wdata = 32'h4444;
    step();
    flush = 1'b0; iss_valid = 1'b0; we = 1'b0;
    set_rd(1, 4, 1'b1);
    #1;
    push("post_flush_busy_r3_r4", 64'h0); check(64'(busy));
    push("flush_write_kept", 64'h4444 << 32); check(64'(rdata));
    set_rd(1, 12, 1'b1);
    #1;
    push("post_flush_busy_r12", 64'h0); check(64'(busy));
    step();
    push("flush_next_busy", 64'h0); check(64'(busy));

    // Reset in the middle of activity clears storage and counters.
    iss_valid = 1'b1; iss_waddr = 7; step();
    step();
    iss_valid = 1'b0;
    we = 1'b1; waddr = 12; wdata = 32'hC;
    step();
    we = 1'b0;
    set_rd(0, 5, 1'b1); set_rd(1, 7, 1'b1);
    #1;
    push("pre_rst_rdata", {32'h70, 32'hDEAD_BEEF}); check(64'(rdata));
    push("pre_rst_busy", 64'h2); check(64'(busy));
    rst = 1'b1;
    #1;
    push("mid_rst_rdata", 64'h0);     check(64'(rdata));
    push("mid_rst_busy", 64'h0);      check(64'(busy));
    push("mid_rst_iss_ready", 64'h0); check(64'(iss_ready));
    step();
    rst = 1'b0;
    #1;
    push("after_rst_rdata_r5_r7", 64'h0); check(64'(rdata));
    push("after_rst_busy_r7", 64'h0);     check(64'(busy));
    push("after_rst_ready_r7", 64'h1);    check(64'(iss_ready));
    set_rd(0, 4, 1'b1); set_rd(1, 12, 1'b1);
    #1;
    push("after_rst_rdata_r4_r12", 64'h0); check(64'(rdata));
    set_rd(0, 9, 1'b1);
    #1;
    push("after_rst_rdata_r9", 64'h0); check(64'(rdata));

    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
